// File: rtl/uart_rx_core.sv
// UART receiver: synchronises rx, detects the start edge, samples each bit at
// mid-bit from a local baud counter and reports bytes, parity and framing errors.
module uart_rx_core #(
    parameter int unsigned CLK_FREQUENCE = 50_000_000,
    parameter int unsigned BAUD_RATE     = 9600,
    parameter bit          PARITY_EN     = 1'b0,
    parameter bit          PARITY_ODD    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned BPS_CNT  = CLK_FREQUENCE / BAUD_RATE - 1;
    localparam int unsigned HALF_CNT = BPS_CNT / 2;
    localparam int unsigned CNT_W    = (BPS_CNT > 0) ? $clog2(BPS_CNT + 1) : 1;

    localparam logic [CNT_W-1:0] BPS_END  = CNT_W'(BPS_CNT);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_CNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_bit_q, par_bit_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_busy_q, rx_busy_d;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic             fall;
    logic             bit_wrap;

    // Idle-high reset values keep reset release from looking like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign fall = rx_prev_q & ~rx_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            rx_busy_q    <= rx_busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        bit_wrap     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_END) begin
                    if (!rx_sync_q) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == BPS_END) begin
                    bit_wrap        = 1'b1;
                    shift_d[idx_q]  = rx_sync_q;
                    idx_d           = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == BPS_END) begin
                    par_bit_d = rx_sync_q;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == BPS_END) begin
                    state_d = S_IDLE;
                    if (rx_sync_q) begin
                        rx_data_d    = shift_q;
                        rx_valid_d   = 1'b1;
                        parity_err_d = PARITY_EN && ((^shift_q ^ par_bit_q) != PARITY_ODD);
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // DATA stays in one state across eight bits, so the counter also wraps per bit.
        if (state_q == S_IDLE || state_d != state_q || bit_wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        rx_busy_d = (state_d != S_IDLE);
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = rx_busy_q;

endmodule
